// File: rtl/vscale_hasti_arbiter.sv
// Two-master HASTI arbiter letting the dmem (p0) and imem (p1) ports share one single-port slave.
// Losers are stalled through hready; completed data phases are parked in a per-master buffer.
module vscale_hasti_arbiter #(
  parameter int RR_ENABLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] p0_haddr,
  input  logic        p0_hwrite,
  input  logic [2:0]  p0_hsize,
  input  logic [2:0]  p0_hburst,
  input  logic        p0_hmastlock,
  input  logic [3:0]  p0_hprot,
  input  logic [1:0]  p0_htrans,
  input  logic [31:0] p0_hwdata,
  output logic [31:0] p0_hrdata,
  output logic        p0_hready,
  output logic        p0_hresp,
  input  logic [31:0] p1_haddr,
  input  logic        p1_hwrite,
  input  logic [2:0]  p1_hsize,
  input  logic [2:0]  p1_hburst,
  input  logic        p1_hmastlock,
  input  logic [3:0]  p1_hprot,
  input  logic [1:0]  p1_htrans,
  input  logic [31:0] p1_hwdata,
  output logic [31:0] p1_hrdata,
  output logic        p1_hready,
  output logic        p1_hresp,
  output logic [31:0] s_haddr,
  output logic        s_hwrite,
  output logic [2:0]  s_hsize,
  output logic [2:0]  s_hburst,
  output logic        s_hmastlock,
  output logic [3:0]  s_hprot,
  output logic [1:0]  s_htrans,
  output logic [31:0] s_hwdata,
  input  logic [31:0] s_hrdata,
  input  logic        s_hready,
  input  logic        s_hresp
);

  typedef enum logic [1:0] {ST_NONE = 2'd0, ST_SLV = 2'd1, ST_BUF = 2'd2} mst_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;

  function automatic logic trans_active(input logic [1:0] htrans);
    return (htrans == 2'd2) || (htrans == 2'd3);
  endfunction

  function automatic mst_state_e next_state(input mst_state_e st, input logic slv_rdy,
                                            input logic hready, input logic req, input logic gnt);
    if (st == ST_SLV && slv_rdy && !hready) return ST_BUF;
    else if (gnt)                           return ST_SLV;
    else if (hready && !req)                return ST_NONE;
    else                                    return st;
  endfunction

  mst_state_e  st0_r, st1_r, st0_s, st1_s;
  logic [31:0] buf0_rdata_r, buf1_rdata_r;
  logic        buf0_resp_r, buf1_resp_r;
  logic        last_gnt_r, lock_act_r, lock_own_r;
  logic        req0_s, req1_s, gnt0_s, gnt1_s;
  logic        cap0_s, cap1_s, lock_drop_s;

  // Reset abandons any outstanding data phase immediately, not just at the next edge
  assign st0_s  = reset ? ST_NONE : st0_r;
  assign st1_s  = reset ? ST_NONE : st1_r;
  assign req0_s = trans_active(p0_htrans);
  assign req1_s = trans_active(p1_htrans);

  // Grant selection: lock owner first, then round-robin or fixed priority on conflict
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (s_hready && !reset) begin
      if (lock_act_r) begin
        if (lock_own_r) gnt1_s = req1_s;
        else            gnt0_s = req0_s;
      end else if (req0_s && req1_s) begin
        if (RR_ENABLE != 32'sd0) begin
          gnt0_s = last_gnt_r;
          gnt1_s = ~last_gnt_r;
        end else begin
          gnt0_s = 1'b1;
        end
      end else begin
        gnt0_s = req0_s;
        gnt1_s = req1_s;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Slave address-phase mux; p0 fields idle on the bus when nobody is granted
  always_comb begin
    if (gnt1_s) begin
      s_haddr = p1_haddr;  s_hwrite = p1_hwrite; s_hsize = p1_hsize;
      s_hburst = p1_hburst; s_hmastlock = p1_hmastlock; s_hprot = p1_hprot;
    end else begin
      s_haddr = p0_haddr;  s_hwrite = p0_hwrite; s_hsize = p0_hsize;
      s_hburst = p0_hburst; s_hmastlock = p0_hmastlock; s_hprot = p0_hprot;
    end
    s_htrans = (gnt0_s | gnt1_s) ? HTRANS_NONSEQ : HTRANS_IDLE;
  end

  assign s_hwdata = (st1_s == ST_SLV) ? p1_hwdata : p0_hwdata;

  // Master-side handshake and response steering
  always_comb begin
    if (st0_s == ST_SLV) p0_hready = s_hready & (~req0_s | gnt0_s);
    else                 p0_hready = ~req0_s | gnt0_s;
    if (st1_s == ST_SLV) p1_hready = s_hready & (~req1_s | gnt1_s);
    else                 p1_hready = ~req1_s | gnt1_s;
    p0_hrdata = (st0_s == ST_BUF) ? buf0_rdata_r : s_hrdata;
    p1_hrdata = (st1_s == ST_BUF) ? buf1_rdata_r : s_hrdata;
    p0_hresp  = (st0_s == ST_BUF) ? buf0_resp_r : ((st0_s == ST_SLV) ? s_hresp : 1'b0);
    p1_hresp  = (st1_s == ST_BUF) ? buf1_resp_r : ((st1_s == ST_SLV) ? s_hresp : 1'b0);
  end

  assign cap0_s      = (st0_s == ST_SLV) && s_hready && !p0_hready;
  assign cap1_s      = (st1_s == ST_SLV) && s_hready && !p1_hready;
  assign lock_drop_s = lock_own_r ? (!p1_hmastlock || p1_htrans == HTRANS_IDLE)
                                  : (!p0_hmastlock || p0_htrans == HTRANS_IDLE);

  // State, response buffers, fairness pointer and bus lock
  always_ff @(posedge clk) begin
    if (reset) begin
      st0_r        <= ST_NONE;
      st1_r        <= ST_NONE;
      buf0_rdata_r <= 32'h0;
      buf1_rdata_r <= 32'h0;
      buf0_resp_r  <= 1'b0;
      buf1_resp_r  <= 1'b0;
      last_gnt_r   <= 1'b1;
      lock_act_r   <= 1'b0;
      lock_own_r   <= 1'b0;
    end else begin
      st0_r <= next_state(st0_s, s_hready, p0_hready, req0_s, gnt0_s);
      st1_r <= next_state(st1_s, s_hready, p1_hready, req1_s, gnt1_s);
      if (cap0_s) begin
        buf0_rdata_r <= s_hrdata;
        buf0_resp_r  <= s_hresp;
      end
      if (cap1_s) begin
        buf1_rdata_r <= s_hrdata;
        buf1_resp_r  <= s_hresp;
      end
      if (gnt0_s)      last_gnt_r <= 1'b0;
      else if (gnt1_s) last_gnt_r <= 1'b1;
      if (gnt0_s && p0_hmastlock) begin
        lock_act_r <= 1'b1;
        lock_own_r <= 1'b0;
      end else if (gnt1_s && p1_hmastlock) begin
        lock_act_r <= 1'b1;
        lock_own_r <= 1'b1;
      end else if (lock_act_r && lock_drop_s) begin
        lock_act_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Bench for vscale_hasti_arbiter: two queued master BFMs, a wait/error-capable memory slave,
// and a read-data scoreboard filled at address acceptance and drained at data-phase completion.
module tb_vscale_hasti_arbiter;

  localparam logic [31:0] ERR_ADDR = 32'h0000_0FF0;

  typedef struct packed { logic [31:0] addr; logic write; logic [31:0] wdata; logic lock; } xfer_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic resp; } exp_t;
  typedef struct packed { logic mst; logic [7:0] stall; } glog_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] p0_haddr = 32'h0, p1_haddr = 32'h0, p0_hwdata = 32'h0, p1_hwdata = 32'h0;
  logic        p0_hwrite = 1'b0, p1_hwrite = 1'b0, p0_hmastlock = 1'b0, p1_hmastlock = 1'b0;
  logic [1:0]  p0_htrans = 2'b00, p1_htrans = 2'b00;
  logic [2:0]  p0_hsize = 3'd2, p1_hsize = 3'd2, p0_hburst = 3'd0, p1_hburst = 3'd0;
  logic [3:0]  p0_hprot = 4'h3, p1_hprot = 4'h3;
  logic [31:0] p0_hrdata, p1_hrdata, s_haddr, s_hwdata, s_hrdata;
  logic        p0_hready, p1_hready, p0_hresp, p1_hresp, s_hwrite, s_hmastlock, s_hready, s_hresp;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;

  vscale_hasti_arbiter #(.RR_ENABLE(1)) dut (
    .clk(clk), .reset(reset),
    .p0_haddr(p0_haddr), .p0_hwrite(p0_hwrite), .p0_hsize(p0_hsize), .p0_hburst(p0_hburst),
    .p0_hmastlock(p0_hmastlock), .p0_hprot(p0_hprot), .p0_htrans(p0_htrans), .p0_hwdata(p0_hwdata),
    .p0_hrdata(p0_hrdata), .p0_hready(p0_hready), .p0_hresp(p0_hresp),
    .p1_haddr(p1_haddr), .p1_hwrite(p1_hwrite), .p1_hsize(p1_hsize), .p1_hburst(p1_hburst),
    .p1_hmastlock(p1_hmastlock), .p1_hprot(p1_hprot), .p1_htrans(p1_htrans), .p1_hwdata(p1_hwdata),
    .p1_hrdata(p1_hrdata), .p1_hready(p1_hready), .p1_hresp(p1_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 64) return 32'hDEAD_BEEF;
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  // Slave model: memory with programmable wait states and a two-cycle ERROR at ERR_ADDR
  logic [31:0] mem [0:1023];
  logic        sl_valid, sl_write, sl_err, sl_second;
  logic [31:0] sl_addr;
  int          sl_cnt, sl_wait_cfg = 0;

  always_comb begin
    s_hready = 1'b1;
    s_hresp  = 1'b0;
    s_hrdata = 32'h0;
    if (sl_valid) begin
      if (sl_cnt > 0)   s_hready = 1'b0;
      else if (sl_err)  begin s_hready = sl_second; s_hresp = 1'b1; end
      if (!sl_write)    s_hrdata = mem[sl_addr[11:2]];
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      sl_valid <= 1'b0; sl_write <= 1'b0; sl_err <= 1'b0; sl_second <= 1'b0;
      sl_addr <= 32'h0; sl_cnt <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else if (s_hready) begin
      if (sl_valid && sl_write) mem[sl_addr[11:2]] <= s_hwdata;
      sl_valid  <= s_htrans[1];
      sl_addr   <= s_haddr;
      sl_write  <= s_hwrite;
      sl_cnt    <= s_htrans[1] ? sl_wait_cfg : 0;
      sl_err    <= s_htrans[1] && (s_haddr == ERR_ADDR);
      sl_second <= 1'b0;
    end else if (sl_cnt > 0) begin
      sl_cnt <= sl_cnt - 1;
    end else begin
      sl_second <= 1'b1;
    end
  end

  xfer_t       q0[$], q1[$];
  exp_t        rq0[$], rq1[$];
  glog_t       glog[$];
  logic [31:0] ref_mem [0:1023];
  logic [1:0]  dp_valid, dp_write, smp_hready, smp_hresp;
  logic [31:0] wdata_r [2];
  logic [31:0] smp_hrdata [2];
  logic [31:0] smp_s_hwdata;
  logic [1:0]  smp_s_htrans;
  logic [7:0]  stall_run [2];
  int          done_cnt [2];
  int          vectors = 0, miscompares = 0;

  function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [31:0] d, input logic l);
    xfer_t x;
    x.addr = a; x.write = w; x.wdata = d; x.lock = l;
    return x;
  endfunction

  task automatic clear_bench();
    q0.delete(); q1.delete(); rq0.delete(); rq1.delete(); glog.delete();
    dp_valid = 2'b00; dp_write = 2'b00;
    for (int m = 0; m < 2; m++) begin
      wdata_r[m] = 32'h0; stall_run[m] = 8'd0; done_cnt[m] = 0;
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
  endtask

  // One clock: drive queue heads, sample mid-cycle, score completions, log acceptances
  task automatic step();
    logic rdy, rsp, req;
    logic [31:0] rd;
    xfer_t x;
    exp_t e;
    if (q0.size() > 0) begin
      p0_htrans = 2'b10; p0_haddr = q0[0].addr; p0_hwrite = q0[0].write; p0_hmastlock = q0[0].lock;
    end else begin
      p0_htrans = 2'b00; p0_hwrite = 1'b0; p0_hmastlock = 1'b0;
    end
    if (q1.size() > 0) begin
      p1_htrans = 2'b10; p1_haddr = q1[0].addr; p1_hwrite = q1[0].write; p1_hmastlock = q1[0].lock;
    end else begin
      p1_htrans = 2'b00; p1_hwrite = 1'b0; p1_hmastlock = 1'b0;
    end
    p0_hwdata = wdata_r[0];
    p1_hwdata = wdata_r[1];
    @(negedge clk);
    smp_s_htrans = s_htrans;
    smp_s_hwdata = s_hwdata;
    for (int m = 0; m < 2; m++) begin
      rdy = (m == 0) ? p0_hready : p1_hready;
      rsp = (m == 0) ? p0_hresp : p1_hresp;
      rd  = (m == 0) ? p0_hrdata : p1_hrdata;
      req = (m == 0) ? (q0.size() > 0) : (q1.size() > 0);
      smp_hready[m] = rdy; smp_hresp[m] = rsp; smp_hrdata[m] = rd;
      if (!reset) begin
        if (dp_valid[m] && rdy) begin
          dp_valid[m] = 1'b0;
          if (!dp_write[m]) begin
            vectors++;
            if ((m == 0 && rq0.size() == 0) || (m == 1 && rq1.size() == 0)) begin
              miscompares++;
              $display("FAIL sb_underflow p%0d: completion with no expected read", m);
            end else begin
              e = (m == 0) ? rq0.pop_front() : rq1.pop_front();
              done_cnt[m]++;
              if (rsp !== e.resp || (!e.resp && rd !== e.data)) begin
                miscompares++;
                $display("FAIL sb_read p%0d addr %h: got data %h resp %b, want data %h resp %b",
                         m, e.addr, rd, rsp, e.data, e.resp);
              end
            end
          end
        end
        if (req && !rdy) stall_run[m] = stall_run[m] + 8'd1;
        if (req && rdy) begin
          x = (m == 0) ? q0.pop_front() : q1.pop_front();
          dp_valid[m] = 1'b1;
          dp_write[m] = x.write;
          if (x.write) begin
            ref_mem[x.addr[11:2]] = x.wdata;
            wdata_r[m] = x.wdata;
          end else begin
            e.addr = x.addr; e.data = ref_mem[x.addr[11:2]]; e.resp = (x.addr == ERR_ADDR);
            if (m == 0) rq0.push_back(e); else rq1.push_back(e);
          end
          glog.push_back('{mst: m[0], stall: stall_run[m]});
          stall_run[m] = 8'd0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_bench();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_bench();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) reset = 1'b0;
      step();
      vectors++;
      if (smp_s_htrans !== 2'b00) begin
        miscompares++; $display("FAIL reset_htrans cyc%0d: got %b want 00", c, smp_s_htrans);
      end
      vectors++;
      if (smp_hready !== 2'b11 || smp_hresp !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_outputs cyc%0d: hready %b hresp %b, want 11 00", c, smp_hready, smp_hresp);
      end
    end
  endtask

  task automatic test_p1_stream();
    do_reset();
    for (int i = 0; i < 3; i++) q1.push_back(mk(32'(i * 4), 1'b0, 32'h0, 1'b0));
    for (int c = 0; c < 4; c++) begin
      step();
      vectors++;
      if (smp_s_htrans !== ((c < 3) ? 2'b10 : 2'b00)) begin
        miscompares++; $display("FAIL stream_htrans cyc%0d: got %b", c, smp_s_htrans);
      end
      vectors++;
      if (smp_hready[1] !== 1'b1) begin
        miscompares++; $display("FAIL stream_hready cyc%0d: got 0 want 1", c);
      end
    end
    vectors++;
    if (done_cnt[1] != 3) begin
      miscompares++; $display("FAIL stream_count: got %0d want 3", done_cnt[1]);
    end
  endtask

  task automatic test_round_robin();
    logic [5:0] exp_m;
    exp_m = 6'b101010;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(32'h40 + 32'(i * 4), 1'b0, 32'h0, 1'b0));
      q1.push_back(mk(32'h80 + 32'(i * 4), 1'b0, 32'h0, 1'b0));
    end
    repeat (8) step();
    vectors++;
    if (glog.size() != 6) begin
      miscompares++; $display("FAIL rr_grants: got %0d grants want 6", glog.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (glog[i].mst !== exp_m[i] || glog[i].stall !== ((i == 0) ? 8'd0 : 8'd1)) begin
          miscompares++;
          $display("FAIL rr_order slot%0d: got p%0d stall %0d, want p%0d stall %0d",
                   i, glog[i].mst, glog[i].stall, exp_m[i], (i == 0) ? 0 : 1);
        end
      end
    end
    vectors++;
    if (done_cnt[0] != 3 || done_cnt[1] != 3) begin
      miscompares++; $display("FAIL rr_done: got %0d/%0d want 3/3", done_cnt[0], done_cnt[1]);
    end
  endtask

  task automatic test_buffer();
    do_reset();
    q1.push_back(mk(32'h100, 1'b0, 32'h0, 1'b0));
    q1.push_back(mk(32'h104, 1'b0, 32'h0, 1'b0));
    step();
    q0.push_back(mk(32'h000, 1'b0, 32'h0, 1'b0));
    step();
    vectors++;
    if (smp_hready[1] !== 1'b0) begin
      miscompares++; $display("FAIL buf_stall: p1_hready got 1 want 0");
    end
    step();
    vectors++;
    if (smp_hready[1] !== 1'b1 || smp_hrdata[1] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL buf_release: p1_hready %b hrdata %h, want 1 deadbeef", smp_hready[1], smp_hrdata[1]);
    end
    repeat (2) step();
    vectors++;
    if (done_cnt[0] != 1 || done_cnt[1] != 2) begin
      miscompares++; $display("FAIL buf_done: got %0d/%0d want 1/2", done_cnt[0], done_cnt[1]);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    q0.push_back(mk(32'h200, 1'b1, 32'h1234_5678, 1'b0));
    q1.push_back(mk(32'h200, 1'b0, 32'h0, 1'b0));
    repeat (2) step();
    vectors++;
    if (smp_s_hwdata !== 32'h1234_5678) begin
      miscompares++; $display("FAIL wr_hwdata: got %h want 12345678", smp_s_hwdata);
    end
    step();
    vectors++;
    if (smp_hrdata[1] !== 32'h1234_5678 || done_cnt[1] != 1) begin
      miscompares++;
      $display("FAIL wr_readback: hrdata %h reads %0d, want 12345678 1", smp_hrdata[1], done_cnt[1]);
    end
  endtask

  task automatic test_lock();
    logic [3:0] exp_rdy1;
    exp_rdy1 = 4'b1000;
    do_reset();
    q0.push_back(mk(32'h50, 1'b0, 32'h0, 1'b1));
    q0.push_back(mk(32'h54, 1'b0, 32'h0, 1'b1));
    q0.push_back(mk(32'h58, 1'b0, 32'h0, 1'b0));
    q1.push_back(mk(32'h60, 1'b0, 32'h0, 1'b0));
    for (int c = 0; c < 4; c++) begin
      step();
      vectors++;
      if (smp_hready[1] !== exp_rdy1[c]) begin
        miscompares++; $display("FAIL lock_p1_hready cyc%0d: got %b want %b", c, smp_hready[1], exp_rdy1[c]);
      end
    end
    step();
    vectors++;
    if (glog.size() != 4 || glog[3].mst !== 1'b1 || glog[3].stall !== 8'd3 || glog[2].mst !== 1'b0) begin
      miscompares++; $display("FAIL lock_order: got %0d grants, last p%0d stall %0d, want 4 p1 3",
                              glog.size(), glog[glog.size()-1].mst, glog[glog.size()-1].stall);
    end
  endtask

  task automatic test_error_reset();
    logic [4:0] exp_rdy0, exp_rsp0;
    exp_rdy0 = 5'b10001;
    exp_rsp0 = 5'b11000;
    do_reset();
    sl_wait_cfg = 2;
    q0.push_back(mk(ERR_ADDR, 1'b0, 32'h0, 1'b0));
    q1.push_back(mk(32'h10, 1'b0, 32'h0, 1'b0));
    q1.push_back(mk(32'h14, 1'b0, 32'h0, 1'b0));
    for (int c = 0; c < 5; c++) begin
      step();
      vectors++;
      if (smp_hready[0] !== exp_rdy0[c] || smp_hresp[0] !== exp_rsp0[c]) begin
        miscompares++;
        $display("FAIL err_p0 cyc%0d: hready %b hresp %b, want %b %b",
                 c, smp_hready[0], smp_hresp[0], exp_rdy0[c], exp_rsp0[c]);
      end
    end
    step();
    vectors++;
    if (smp_hready[1] !== 1'b0 || glog.size() != 2 || glog[1].stall !== 8'd4) begin
      miscompares++; $display("FAIL err_p1_stall: p1_hready %b grants %0d", smp_hready[1], glog.size());
    end
    clear_bench();
    sl_wait_cfg = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    vectors++;
    if (smp_s_htrans !== 2'b00 || smp_hready !== 2'b11 || smp_hresp !== 2'b00) begin
      miscompares++;
      $display("FAIL err_after_reset: htrans %b hready %b hresp %b, want 00 11 00",
               smp_s_htrans, smp_hready, smp_hresp);
    end
    q1.push_back(mk(32'h30, 1'b0, 32'h0, 1'b0));
    repeat (2) step();
    vectors++;
    if (done_cnt[1] != 1 || smp_hresp[1] !== 1'b0) begin
      miscompares++; $display("FAIL err_fresh_read: reads %0d hresp %b, want 1 0", done_cnt[1], smp_hresp[1]);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_p1_stream();
    test_round_robin();
    test_buffer();
    test_write_read();
    test_lock();
    test_error_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
